alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a 32-bit ALU: grant at N+1, result valid at N+3.
// The result is held in DONE until c_ready; new requests are not sampled until IDLE.
module alu_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        c_valid,
    input  logic        c_ready,
    output logic        c_id,
    output logic [31:0] c,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;

    // last_q names the requester served most recently; resetting it to the other
    // requester makes FIRST_PRIO win the first tie.
    localparam logic LAST_INIT = (FIRST_PRIO == 0);

    state_t      state_q, state_d;
    logic        win_q, win_d;
    logic        last_q, last_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic        c_id_q, c_id_d;
    logic [31:0] alu_res;
    logic        big_shift;

    always_comb begin
        big_shift = |b_q[31:5];
        case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q - b_q;
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = big_shift ? 32'd0 : (a_q >> b_q[4:0]);
            3'b101:  alu_res = big_shift ? {32{a_q[31]}}
                                         : $unsigned($signed(a_q) >>> b_q[4:0]);
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        c_id_d  = c_id_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d   = (req0 && req1) ? ~last_q : req1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                op_d    = win_q ? op1 : op0;
                a_d     = win_q ? a1 : a0;
                b_d     = win_q ? b1 : b0;
                last_d  = win_q;
                state_d = EXEC;
            end
            EXEC: begin
                c_d     = alu_res;
                c_id_d  = win_q;
                state_d = DONE;
            end
            DONE: begin
                if (c_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= LAST_INIT;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            c_id_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            c_id_q  <= c_id_d;
        end
    end

    // Grant is masked by reset so an aborted GRANT cycle never pulses.
    assign gnt0    = (state_q == GRANT) && !win_q && !reset;
    assign gnt1    = (state_q == GRANT) &&  win_q && !reset;
    assign c_valid = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign c       = c_q;
    assign c_id    = c_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_alu_arbiter;
    localparam int FIRST_PRIO = 0;

    logic        clk = 1'b0;
    logic        reset, req0, req1, c_ready;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, c_valid, c_id, busy;
    logic [31:0] c;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;

    alu_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .c_valid(c_valid), .c_ready(c_ready),
        .c_id(c_id), .c(c), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            3'd5: r = (b >= 32) ? {32{a[31]}} : (a[31] ? ~((~a) >> b[4:0]) : (a >> b[4:0]));
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gnt0) begin who = 0; break; end
            if (gnt1) begin who = 1; break; end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (c_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; c_ready = 1'b1;
        op0 = 3'd0; op1 = 3'd0; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        step(); step();
        reset = 1'b0;
        model_last = 1 - FIRST_PRIO;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({gnt0, gnt1, c_valid, c_id, busy} !== 5'b0 || c !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: gnt0=%b gnt1=%b c_valid=%b c_id=%b busy=%b c=%h, want all 0",
                     gnt0, gnt1, c_valid, c_id, busy, c);
        end
    endtask

    task automatic test_single;
        op0 = 3'd0; a0 = 32'd7; b0 = 32'd5; c_ready = 1'b1; req0 = 1'b1;
        step();
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_fail++; $display("FAIL single_gnt_n1: gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
        end
        req0 = 1'b0;
        step();
        n_checks++;
        if ({gnt0, gnt1, c_valid} !== 3'b0) begin
            n_fail++; $display("FAIL single_n2: gnt0=%b gnt1=%b c_valid=%b, want 0", gnt0, gnt1, c_valid);
        end
        step();
        n_checks++;
        if (c_valid !== 1'b1 || c !== 32'd12 || c_id !== 1'b0) begin
            n_fail++; $display("FAIL single_n3: c_valid=%b c=%0d c_id=%b, want 1 12 0", c_valid, c, c_id);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_n4_busy: busy=%b, want 0", busy);
        end
        model_last = 0;
    endtask

    task automatic test_round_robin;
        int exp_seq[3] = '{0, 1, 0};
        int who;
        bit ok;
        do_reset();
        op0 = 3'd0; a0 = 32'd100; b0 = 32'd1;
        op1 = 3'd1; a1 = 32'd50;  b1 = 32'd8;
        req0 = 1'b1; req1 = 1'b1; c_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(who);
            n_checks++;
            if (who != exp_seq[k]) begin
                n_fail++; $display("FAIL rr_grant_%0d: granted %0d, want %0d", k, who, exp_seq[k]);
            end
            wait_valid(ok);
            n_checks++;
            if (!ok || c_id !== exp_seq[k][0] ||
                c !== ref_alu(exp_seq[k] == 0 ? op0 : op1, exp_seq[k] == 0 ? a0 : a1,
                              exp_seq[k] == 0 ? b0 : b1)) begin
                n_fail++; $display("FAIL rr_result_%0d: valid=%b c_id=%b c=%0d, want id %0d", k, ok, c_id, c, exp_seq[k]);
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        model_last = 0;
        step();
    endtask

    task automatic test_shift_boundaries;
        logic [2:0]  t_op[4]  = '{3'b101, 3'b101, 3'b100, 3'b001};
        logic [31:0] t_a[4]   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0};
        logic [31:0] t_b[4]   = '{32'd4, 32'd40, 32'd40, 32'd1};
        logic [31:0] t_exp[4] = '{32'hF800_0000, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        int who;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            op0 = t_op[k]; a0 = t_a[k]; b0 = t_b[k]; req0 = 1'b1; c_ready = 1'b1;
            wait_grant(who);
            req0 = 1'b0;
            wait_valid(ok);
            n_checks++;
            if (!ok || c !== t_exp[k]) begin
                n_fail++; $display("FAIL shift_case_%0d: valid=%b c=%h, want %h", k, ok, c, t_exp[k]);
            end
            step();
        end
        model_last = 0;
    endtask

    task automatic test_unused_op;
        op0 = 3'b111; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; req0 = 1'b1; c_ready = 1'b1;
        step();
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL unused_gnt: gnt0=%b, want 1", gnt0);
        end
        req0 = 1'b0;
        step(); step();
        n_checks++;
        if (c_valid !== 1'b1 || c !== 32'd0) begin
            n_fail++; $display("FAIL unused_result: c_valid=%b c=%h, want 1 0", c_valid, c);
        end
        step();
        model_last = 0;
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_c;
        int who;
        bit ok;
        op1 = 3'b011; a1 = 32'h1234_0000; b1 = 32'h0000_5678; req1 = 1'b1; c_ready = 1'b0;
        exp_c = ref_alu(op1, a1, b1);
        wait_grant(who);
        req1 = 1'b0;
        wait_valid(ok);
        for (int i = 0; i < 5; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            op0 = 3'($urandom); op1 = 3'($urandom);
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            step();
            n_checks++;
            if (!ok || c_valid !== 1'b1 || c !== exp_c || c_id !== 1'b1 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d: c_valid=%b c=%h c_id=%b gnt=%b%b, want 1 %h 1 00",
                         i, c_valid, c, c_id, gnt0, gnt1, exp_c);
            end
        end
        req0 = 1'b0; req1 = 1'b0; c_ready = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || c_valid !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_release: busy=%b c_valid=%b, want 0 0", busy, c_valid);
        end
        model_last = 1;
    endtask

    task automatic test_random;
        int who, exp_w, stall;
        bit ok, want0, want1;
        logic [31:0] exp_c;
        for (int it = 0; it < 40; it++) begin
            want0 = req0 | 1'($urandom);
            want1 = req1 | 1'($urandom);
            if (!want0 && !want1) want0 = 1'b1;
            req0 = want0; req1 = want1;
            op0 = 3'($urandom); op1 = 3'($urandom);
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom % 2) ? 32'($urandom_range(0, 40)) : $urandom;
            b1 = ($urandom % 2) ? 32'($urandom_range(0, 40)) : $urandom;
            c_ready = 1'($urandom);
            exp_w = (want0 && want1) ? 1 - model_last : (want1 ? 1 : 0);
            wait_grant(who);
            n_checks++;
            if (who != exp_w) begin
                n_fail++; $display("FAIL random_grant_%0d: granted %0d, want %0d", it, who, exp_w);
            end
            model_last = exp_w;
            exp_c = (exp_w == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
            if (exp_w == 0) req0 = 1'b0; else req1 = 1'b0;
            step();
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            op0 = 3'($urandom); op1 = 3'($urandom);
            wait_valid(ok);
            stall = c_ready ? 0 : $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                n_checks++;
                if (!ok || c_valid !== 1'b1 || c !== exp_c || c_id !== exp_w[0]) begin
                    n_fail++;
                    $display("FAIL random_result_%0d: valid=%b c=%h c_id=%b, want %h id %0d",
                             it, c_valid, c, c_id, exp_c, exp_w);
                end
                if (s == stall) c_ready = 1'b1;
                step();
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL random_idle_%0d: busy=%b, want 0", it, busy);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        int who;
        bit seen;
        op0 = 3'd0; a0 = 32'd1; b0 = 32'd2; req0 = 1'b1; c_ready = 1'b1;
        wait_grant(who);
        req0 = 1'b0;
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({gnt0, gnt1, c_valid, c_id, busy} !== 5'b0 || c !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: gnt=%b%b c_valid=%b c_id=%b busy=%b c=%h, want all 0",
                     gnt0, gnt1, c_valid, c_id, busy, c);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (c_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL reset_mid_no_valid: c_valid seen=%b, want 0", seen);
        end
        req0 = 1'b1; req1 = 1'b1;
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_grant: gnt0=%b gnt1=%b, want 0 0", gnt0, gnt1);
        end
        step();
        reset = 1'b0;
        wait_grant(who);
        n_checks++;
        if (who != FIRST_PRIO) begin
            n_fail++; $display("FAIL reset_tie_prio: granted %0d, want %0d", who, FIRST_PRIO);
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_shift_boundaries();
        test_unused_op();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule
